// File: rtl/kbd_fifo.sv
// Keyboard scan-code FIFO between the ps2 receiver and the CPU port space.
// Data port pops the head; status/control port reports state, flushes and sets irq enable.
module kbd_fifo #(
    parameter int          AW        = 4,
    parameter logic [15:0] PORT_DATA = 16'h0022,
    parameter logic [15:0] PORT_STAT = 16'h0023
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        kb_done,
    input  logic [7:0]  kb_data,
    input  logic [15:0] address,
    input  logic [7:0]  data_o,
    input  logic        we,
    input  logic        read,
    output logic [7:0]  port_q,
    output logic        port_hit,
    output logic        irq
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          ovf, irq_en;
    logic          empty, full, hit_data, hit_stat;
    logic          pop, push, flush, ovf_set, ovf_clr, ctrl_wr;

    assign hit_data = (address == PORT_DATA);
    assign hit_stat = (address == PORT_STAT);
    assign port_hit = hit_data | hit_stat;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH[AW:0]);
    assign pop     = read & hit_data & ~empty;
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign push    = kb_done & (~full | pop);
    assign ovf_set = kb_done & full & ~pop;
    assign ctrl_wr = we & hit_stat;
    assign flush   = ctrl_wr & data_o[0];
    assign ovf_clr = ctrl_wr & data_o[7];

    assign irq = irq_en & ~empty;

    always_comb begin
        port_q = 8'h00;
        if (hit_data)
            port_q = empty ? 8'h00 : mem[rp];
        else if (hit_stat)
            port_q = {ovf, full, irq_en, 5'(count)};
    end

    // Storage is not reset; pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (push)
            mem[wp] <= kb_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (flush) begin
                wp    <= '0;
                rp    <= '0;
                count <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop)  rp <= rp + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
            end
            if (ctrl_wr)
                irq_en <= data_o[1];
            // Set wins over a same-cycle clear.
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_kbd_fifo.sv
// Directed bench for kbd_fifo: push/pop ordering, overflow, flush, wrap and async reset.
module tb_kbd_fifo;
    localparam logic [15:0] PD = 16'h0022;
    localparam logic [15:0] PS = 16'h0023;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        kb_done = 1'b0;
    logic [7:0]  kb_data = 8'h00;
    logic [15:0] address = PD;
    logic [7:0]  data_o = 8'h00;
    logic        we = 1'b0;
    logic        read = 1'b0;
    logic [7:0]  port_q;
    logic        port_hit;
    logic        irq;

    int checks = 0;
    int errors = 0;

    kbd_fifo dut (
        .clock(clock), .reset_n(reset_n), .kb_done(kb_done), .kb_data(kb_data),
        .address(address), .data_o(data_o), .we(we), .read(read),
        .port_q(port_q), .port_hit(port_hit), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        kb_done = 1'b1;
        kb_data = b;
        step();
        kb_done = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address = a;
        data_o  = d;
        we      = 1'b1;
        step();
        we      = 1'b0;
    endtask

    task automatic rd(output logic [7:0] v);
        address = PD;
        read    = 1'b1;
        #1 v = port_q;
        step();
        read    = 1'b0;
    endtask

    task automatic stat(output logic [7:0] v);
        address = PS;
        #1 v = port_q;
    endtask

    logic [7:0] v;

    initial begin
        #12 reset_n = 1'b1;
        step();

        // reset state
        address = PD;
        #1 chk("rst_data", port_q, 8'h00);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        chk("rst_hit_data", {7'd0, port_hit}, 8'h01);
        address = 16'h0024;
        #1 chk("rst_hit_other", {7'd0, port_hit}, 8'h00);
        chk("rst_q_other", port_q, 8'h00);
        stat(v); chk("rst_stat", v, 8'h00);
        chk("rst_hit_stat", {7'd0, port_hit}, 8'h01);

        // basic push/pop with irq enabled
        wr(PS, 8'h02);
        push(8'h1C);
        chk("t1_irq_after_push", {7'd0, irq}, 8'h01);
        step();
        push(8'hF0);
        step();
        push(8'h1C);
        stat(v); chk("t1_stat3", v, 8'h23);
        rd(v); chk("t1_rd0", v, 8'h1C);
        rd(v); chk("t1_rd1", v, 8'hF0);
        rd(v); chk("t1_rd2", v, 8'h1C);
        chk("t1_irq_empty", {7'd0, irq}, 8'h00);
        stat(v); chk("t1_stat_empty", v, 8'h20);
        rd(v); chk("t1_rd_empty", v, 8'h00);
        stat(v); chk("t1_stat_after", v, 8'h20);

        // overflow
        wr(PS, 8'h00);
        for (int i = 0; i < 17; i++) push(8'(i));
        stat(v); chk("t2_stat_ovf", v, 8'hD0);
        chk("t2_irq_dis", {7'd0, irq}, 8'h00);
        for (int i = 0; i < 16; i++) begin
            rd(v); chk("t2_rd", v, 8'(i));
        end
        wr(PS, 8'h80);
        stat(v); chk("t2_stat_clr", v, 8'h00);

        // push while full with simultaneous pop
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        stat(v); chk("t3_full", v, 8'h50);
        address = PD;
        read    = 1'b1;
        kb_done = 1'b1;
        kb_data = 8'hAA;
        #1 chk("t3_head", port_q, 8'h20);
        step();
        read    = 1'b0;
        kb_done = 1'b0;
        stat(v); chk("t3_stat", v, 8'h50);
        for (int i = 1; i < 16; i++) begin
            rd(v); chk("t3_rd", v, 8'h20 + 8'(i));
        end
        rd(v); chk("t3_rd_aa", v, 8'hAA);
        stat(v); chk("t3_stat_empty", v, 8'h00);

        // flush beats a same-cycle push, irq_en kept
        wr(PS, 8'h02);
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        stat(v); chk("t4_stat5", v, 8'h25);
        kb_done = 1'b1;
        kb_data = 8'h77;
        wr(PS, 8'h03);
        kb_done = 1'b0;
        stat(v); chk("t4_stat_flush", v, 8'h20);
        chk("t4_irq", {7'd0, irq}, 8'h00);
        rd(v); chk("t4_rd_empty", v, 8'h00);

        // pointer wrap, 1:1 interleave
        for (int i = 0; i < 40; i++) begin
            push(8'h80 + 8'(i));
            stat(v); chk("t5_count", v, 8'h21);
            rd(v); chk("t5_rd", v, 8'h80 + 8'(i));
        end
        stat(v); chk("t5_end", v, 8'h20);

        // async reset mid-burst
        wr(PS, 8'h02);
        for (int i = 0; i < 7; i++) push(8'h60 + 8'(i));
        kb_done = 1'b1;
        kb_data = 8'h99;
        stat(v); chk("t6_stat7", v, 8'h27);
        chk("t6_irq_before", {7'd0, irq}, 8'h01);
        #1 reset_n = 1'b0;
        #1 chk("t6_stat_rst", port_q, 8'h00);
        chk("t6_irq_rst", {7'd0, irq}, 8'h00);
        kb_done = 1'b0;
        address = PD;
        #1 chk("t6_data_rst", port_q, 8'h00);
        step();
        reset_n = 1'b1;
        step();
        stat(v); chk("t6_stat_after", v, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
